// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake bundle between the core and the iterative mul/div unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, flush, funct3, a, b, input busy, done, result);
  modport slave  (input start, flush, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M execution unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and result selection in a final cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d, spec_q, spec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // product, or quotient in the low half
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplicand / divisor magnitude, or special result
  logic [XLEN-1:0]   res_q, res_d;
  logic              busy_q, done_q;

  // Accept-time decode of signs, magnitudes and special division cases
  logic [2:0]      f3;
  logic            a_sgn, b_sgn, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign f3       = bus.funct3;
  assign a_sgn    = bus.a[XLEN-1] & ((f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110));
  assign b_sgn    = bus.b[XLEN-1] & ((f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110));
  assign a_mag    = a_sgn ? (~bus.a + XLEN'(1)) : bus.a;
  assign b_mag    = b_sgn ? (~bus.b + XLEN'(1)) : bus.b;
  assign div_zero = f3[2] & (bus.b == '0);
  assign div_ovf  = ((f3 == 3'b100) | (f3 == 3'b110)) &
                    (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b == '1);
  assign spec_res = div_zero ? (f3[1] ? bus.a : '1) : (f3[1] ? '0 : bus.a);

  // One iteration of multiply or divide
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_sh, div_diff;
  logic            div_ok;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {rem_q, acc_q[XLEN-1]};
  assign div_diff = div_sh - {2'b0, opb_q};
  assign div_ok   = ~div_diff[XLEN+1];

  // Sign fix-up of the raw magnitudes
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              neg;

  assign neg      = sa_q ^ sb_q;
  assign prod_fix = neg  ? (~acc_q + (2*XLEN)'(1)) : acc_q;
  assign quo_fix  = neg  ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
  assign rem_fix  = sa_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    spec_d  = spec_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opb_d   = opb_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.start) begin
          op_d   = f3;
          sa_d   = a_sgn;
          sb_d   = b_sgn;
          cnt_d  = '0;
          rem_d  = '0;
          spec_d = div_zero | div_ovf;
          if (div_zero | div_ovf) begin
            opb_d   = spec_res;
            acc_d   = '0;
            state_d = S_FIX;
          end else begin
            opb_d   = f3[2] ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (f3[2] ? a_mag : b_mag)};
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            rem_d = div_ok ? div_diff[XLEN:0] : div_sh[XLEN:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ok};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (spec_q) begin
            res_d = opb_q;
          end else begin
            case (op_q)
              3'b000:                 res_d = prod_fix[XLEN-1:0];
              3'b001, 3'b010, 3'b011: res_d = prod_fix[2*XLEN-1:XLEN];
              3'b100, 3'b101:         res_d = quo_fix;
              default:                res_d = rem_fix;
            endcase
          end
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      spec_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      spec_q  <= spec_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      busy_q  <= (state_d == S_CALC) || (state_d == S_FIX);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule
